// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
// Digit limits, state encoding and the BCD step helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] TENTHS_MAX   = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Value a digit takes after an optional increment, wrapping at lim.
  function automatic logic [3:0] bcd_next(
    input logic [3:0] d,
    input logic       inc,
    input logic [3:0] lim
  );
    if (!inc) begin
      return d;
    end
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch cascade.
// Wraps to 0 after LIMIT; carry is combinational so the chain settles in one cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == LIMIT);

  // Digit register: cleared by reset or clear, else steps on inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= 4'd0;
    end else begin
      digit <= bcd_next(digit, inc, LIMIT);
    end
  end

endmodule

// File: rtl/tick_stopwatch_bcd.sv
// M:SS.t stopwatch fed by a 100 ms tick, with run/pause/full control.
// Optional lap capture registers exist only when STOPWATCH_LAP_EN is defined.
module tick_stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINUTES = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic [3:0] lap_tenths,
  output logic [3:0] lap_sec_ones,
  output logic [3:0] lap_sec_tens,
  output logic [3:0] lap_minutes,
  output logic       lap_valid,
`endif
  output logic       running,
  output logic       full,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes
);

  localparam logic [3:0] MIN_MAX = 4'(MAX_MINUTES);

  state_t state;

  logic at_max;
  logic cnt_en;
  logic c_tenths;
  logic c_ones;
  logic c_tens;
  logic min_carry_unused;

  // Count is pinned at MAX:59.9; a tick there saturates instead of wrapping.
  assign at_max = (minutes  == MIN_MAX)
               && (sec_tens == SEC_TENS_MAX)
               && (sec_ones == SEC_ONES_MAX)
               && (tenths   == TENTHS_MAX);

  assign cnt_en = tick
               && (state == ST_RUN)
               && !at_max
               && !clear;

  bcd_digit_counter #(.LIMIT(TENTHS_MAX)) u_tenths (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (cnt_en),
    .digit (tenths),
    .carry (c_tenths)
  );

  bcd_digit_counter #(.LIMIT(SEC_ONES_MAX)) u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (c_tenths),
    .digit (sec_ones),
    .carry (c_ones)
  );

  bcd_digit_counter #(.LIMIT(SEC_TENS_MAX)) u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (c_ones),
    .digit (sec_tens),
    .carry (c_tens)
  );

  // Never fires: saturation stops the cascade before minutes can wrap.
  bcd_digit_counter #(.LIMIT(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (c_tens),
    .digit (minutes),
    .carry (min_carry_unused)
  );

  // Control FSM with registered running/full flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      full    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (tick && at_max) begin
            state   <= ST_FULL;
            running <= 1'b0;
            full    <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_FULL: begin
          state <= ST_FULL;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          full    <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [3:0] nx_tenths;
  logic [3:0] nx_ones;
  logic [3:0] nx_tens;
  logic [3:0] nx_min;
  logic       lap_ok;

  // Lap sees the digits as they will be after this edge.
  assign nx_tenths = bcd_next(tenths,   cnt_en,   TENTHS_MAX);
  assign nx_ones   = bcd_next(sec_ones, c_tenths, SEC_ONES_MAX);
  assign nx_tens   = bcd_next(sec_tens, c_ones,   SEC_TENS_MAX);
  assign nx_min    = bcd_next(minutes,  c_tens,   MIN_MAX);

  assign lap_ok = lap
               && ((state == ST_RUN) || (state == ST_PAUSE));

  // Lap snapshot registers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_tenths   <= 4'd0;
      lap_sec_ones <= 4'd0;
      lap_sec_tens <= 4'd0;
      lap_minutes  <= 4'd0;
      lap_valid    <= 1'b0;
    end else if (lap_ok) begin
      lap_tenths   <= nx_tenths;
      lap_sec_ones <= nx_ones;
      lap_sec_tens <= nx_tens;
      lap_minutes  <= nx_min;
      lap_valid    <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tick_stopwatch_bcd.sv
// Bench for tick_stopwatch_bcd: count-in-tenths model checked every cycle,
// plus literal display expectations at the interesting points.
module tb_tick_stopwatch_bcd;

  localparam int MAXM  = 9;
  localparam int MAXC  = MAXM * 600 + 599;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic       running;
  logic       full;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] minutes;
`ifdef STOPWATCH_LAP_EN
  logic [3:0] lap_tenths;
  logic [3:0] lap_sec_ones;
  logic [3:0] lap_sec_tens;
  logic [3:0] lap_minutes;
  logic       lap_valid;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int ms;
  int mc;
  int ml;
  int mlv;

  always #5 clk = ~clk;

  tick_stopwatch_bcd #(.MAX_MINUTES(MAXM)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap          (lap),
    .lap_tenths   (lap_tenths),
    .lap_sec_ones (lap_sec_ones),
    .lap_sec_tens (lap_sec_tens),
    .lap_minutes  (lap_minutes),
    .lap_valid    (lap_valid),
`endif
    .running    (running),
    .full       (full),
    .tenths     (tenths),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .minutes    (minutes)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int next_count();
    if (ms == M_RUN && tick && mc < MAXC) begin
      return mc + 1;
    end
    return mc;
  endfunction

  // Behavioural model: whole count held as tenths of a second.
  always @(posedge clk) begin
    if (rst || clear) begin
      ms  <= M_IDLE;
      mc  <= 0;
      ml  <= 0;
      mlv <= 0;
    end else begin
      if (lap && (ms == M_RUN || ms == M_PAUSE)) begin
        ml  <= next_count();
        mlv <= 1;
      end
      case (ms)
        M_IDLE:  if (start_stop) ms <= M_RUN;
        M_PAUSE: if (start_stop) ms <= M_RUN;
        M_RUN: begin
          if (tick && mc < MAXC) mc <= mc + 1;
          if (start_stop) ms <= M_PAUSE;
          else if (tick && mc == MAXC) ms <= M_FULL;
        end
        default: ms <= ms;
      endcase
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tenths",   32'(tenths),   32'(mc % 10));
      chk("m_sec_ones", 32'(sec_ones), 32'((mc / 10) % 10));
      chk("m_sec_tens", 32'(sec_tens), 32'(((mc / 10) % 60) / 10));
      chk("m_minutes",  32'(minutes),  32'(mc / 600));
      chk("m_running",  32'(running),  32'(ms == M_RUN));
      chk("m_full",     32'(full),     32'(ms == M_FULL));
`ifdef STOPWATCH_LAP_EN
      chk("m_lap_valid", 32'(lap_valid), 32'(mlv));
      chk("m_lap_t",   32'(lap_tenths),   32'(ml % 10));
      chk("m_lap_o",   32'(lap_sec_ones), 32'((ml / 10) % 10));
      chk("m_lap_s",   32'(lap_sec_tens), 32'(((ml / 10) % 60) / 10));
      chk("m_lap_m",   32'(lap_minutes),  32'(ml / 600));
`endif
    end
  end

  task automatic step(input bit t, input bit s,
                      input bit c, input bit l = 1'b0);
    tick = t;
    start_stop = s;
    clear = c;
    lap = l;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic expect_disp(input string nm,
                             input int m, input int st,
                             input int so, input int t,
                             input bit r, input bit f);
    chk({nm, "_min"},  32'(minutes),  32'(m));
    chk({nm, "_st"},   32'(sec_tens), 32'(st));
    chk({nm, "_so"},   32'(sec_ones), 32'(so));
    chk({nm, "_t"},    32'(tenths),   32'(t));
    chk({nm, "_run"},  32'(running),  32'(r));
    chk({nm, "_full"}, 32'(full),     32'(f));
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_en = 1'b1;
    expect_disp("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 0, 0);
    expect_disp("idle_tick", 0, 0, 0, 0, 0, 0);

    step(0, 1, 0);
    ticks(10);
    expect_disp("run10", 0, 0, 1, 0, 1, 0);
    rst = 1'b1;
    step(0, 0, 0);
    expect_disp("rst_mid", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    step(0, 1, 0);
    ticks(5);
    step(0, 1, 0);
    expect_disp("pause5", 0, 0, 0, 5, 0, 0);
    ticks(3);
    expect_disp("pause_hold", 0, 0, 0, 5, 0, 0);
    step(0, 1, 0);
    ticks(2);
    expect_disp("resume", 0, 0, 0, 7, 1, 0);

    step(0, 0, 1);
    expect_disp("clear1", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);
    ticks(599);
    expect_disp("s59_9", 0, 5, 9, 9, 1, 0);
    ticks(1);
    expect_disp("m1", 1, 0, 0, 0, 1, 0);
    ticks(MAXC - 600);
    expect_disp("at_max", 9, 5, 9, 9, 1, 0);
    ticks(1);
    expect_disp("sat", 9, 5, 9, 9, 0, 1);
    step(0, 1, 0);
    ticks(2);
    expect_disp("full_hold", 9, 5, 9, 9, 0, 1);
    step(0, 0, 1);
    expect_disp("clear_full", 0, 0, 0, 0, 0, 0);

    step(0, 1, 0);
    ticks(3);
    step(1, 1, 0);
    expect_disp("ss_tick_run", 0, 0, 0, 4, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    expect_disp("ss_tick_pause", 0, 0, 0, 4, 1, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    expect_disp("clr_tick", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);
    expect_disp("after_clr", 0, 0, 0, 0, 1, 0);

`ifdef STOPWATCH_LAP_EN
    step(0, 0, 1);
    step(0, 1, 0);
    ticks(24);
    step(1, 0, 0, 1);
    chk("lap_valid", 32'(lap_valid), 32'd1);
    chk("lap_min",   32'(lap_minutes),  32'd0);
    chk("lap_st",    32'(lap_sec_tens), 32'd0);
    chk("lap_so",    32'(lap_sec_ones), 32'd2);
    chk("lap_t",     32'(lap_tenths),   32'd5);
    step(0, 0, 1);
    chk("lap_clr", 32'(lap_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("lap_idle", 32'(lap_valid), 32'd0);
    chk("lap_idle_t", 32'(lap_tenths), 32'd0);
`endif

    step(0, 0, 0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch_bcd.md
Name: tick_stopwatch_bcd

Overview:
- Consumer of the 100 ms one-cycle tick strobe from the team's clock divider; turns the tick stream into a BCD stopwatch (M:SS.t) for the seven-segment display driver.
- Start/stop and clear come in as one-cycle pulses from the debounced button logic.
- The block owns the run/pause/full state machine and the cascaded BCD digit counters.

Parameters:
- MAX_MINUTES, 9: highest minutes value before saturation (1..9).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-clk-wide 100 ms strobe; never asserted on consecutive cycles
- start_stop  input  1  one-clk pulse; toggles run/pause
- clear  input  1  one-clk pulse; returns to zero/idle
- running  output  1  high while in RUN
- full  output  1  high while in FULL (saturated)
- tenths  output  4  BCD 0..9
- sec_ones  output  4  BCD 0..9
- sec_tens  output  4  BCD 0..5
- minutes  output  4  BCD 0..MAX_MINUTES

Behaviour:
- Reset: the state goes to IDLE and every output is 0 (running=0, full=0, all digits 0).
- All outputs are registered. A qualifying event updates the outputs on the clock edge at which it is sampled, so they are visible the next cycle.
- States:
  - IDLE: digits are 0. start_stop moves to RUN. tick is ignored.
  - RUN: each tick increments the count by 0.1 s. start_stop moves to PAUSE.
  - PAUSE: digits are held. start_stop moves to RUN. tick is ignored.
  - FULL: digits are held at MAX_MINUTES:59.9. start_stop is ignored.
- clear in any state: moves to IDLE, zeroes all digits and drops full.
- Increment cascade, evaluated in one cycle:
  - tenths 9→0 carries into sec_ones.
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into minutes.
  - Each digit increments only when every lower digit is at its limit.
- Saturation: a tick in RUN while the count is MAX_MINUTES:59.9 leaves the digits unchanged and moves to FULL (full=1, running=0). The count never wraps.
- Priority in the same cycle:
  - clear beats everything.
  - start_stop in RUN plus tick: the tick is counted and the state moves to PAUSE.
  - start_stop in PAUSE/IDLE plus tick: the state moves to RUN and that tick is not counted.
- running reflects the state register (RUN only).
- Digits never hold non-BCD values.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With the macro defined, the block adds:
  - Input lap (1-clk pulse).
  - Outputs lap_tenths, lap_sec_ones, lap_sec_tens, lap_minutes (4 bits each) and lap_valid (1 bit).
  - A lap pulse in RUN or PAUSE captures the current digits, including any same-cycle increment, and sets lap_valid.
  - lap in IDLE/FULL is ignored.
  - clear and rst zero the lap registers and lap_valid.
- Without the macro: none of the lap ports or logic exist, and the port list is exactly as above.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_FULL=2'd3;
  - digit limit constants TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5.
- One sub-module, bcd_digit_counter:
  - parameter LIMIT; inputs clk, rst, clr, inc; outputs digit[3:0], carry (combinational: inc && digit==LIMIT).
  - Instantiated four times and chained by carry.
- The FSM and saturation detect stay in the top module.

Test Plan:
- rst, then start_stop, then 10 ticks → running=1, display 0:01.0; rst mid-run → all outputs 0 next cycle, state IDLE.
- Start, 5 ticks, start_stop, 3 more ticks, start_stop, 2 ticks → pause holds at 0:00.5; final display 0:00.7.
- Preload via 599 ticks in RUN → 0:59.9; one tick → 1:00.0 (three-digit carry in one cycle).
- Run to 9:59.9 (5999 ticks), one more tick → digits stay 9:59.9, full=1, running=0; start_stop ignored; clear → 0:00.0, full=0, IDLE.
- Same-cycle events:
  - In RUN at 0:00.3, start_stop+tick together → 0:00.4 and PAUSE.
  - In PAUSE, start_stop+tick together → RUN with digits unchanged.
  - clear+tick in RUN → 0:00.0, IDLE.
- (STOPWATCH_LAP_EN) lap at 0:02.4 with a same-cycle tick → lap digits 0:02.5, lap_valid=1; lap in IDLE → no change; clear → lap_valid=0.
